sm3_cf_sched: RTL
=================

Name: sm3_cf_sched

Overview:
- Round-robin scheduler that shares one sm3_CF compression core among NREQ hash requesters, e.g. Picnic commitment, challenge and seed-expansion hashers.
- Grants the core to one requester for a whole message, feeds it one 512-bit block at a time, and chains the intermediate digest internally.
- Returns each block's result with a one-cycle done pulse.
- Sits between the requester hashers and a single sm3_CF instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WDOG_CYCLES, 255, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request; held high while blocks remain
- first  in  NREQ  current block is the first of a message (use iv_in)
- last  in  NREQ  current block is the last of a message
- iv_in  in  NREQ*256  per-requester initial IV; slot i = bits [256*i+255:256*i]
- blk_in  in  NREQ*512  per-requester padded block; slot i = bits [512*i+511:512*i]
- gnt  out  NREQ  one-hot owner; held for the whole message
- done  out  NREQ  one-cycle pulse to the owner; hash_out valid
- hash_out  out  256  compression result of the last completed block
- busy  out  1  state != IDLE
- wdog_err  out  1  one-cycle pulse on watchdog abort; tied 0 when the feature is absent
- cf_start  out  1  to sm3_CF; held high until cf_end
- cf_iv  out  256  to sm3_CF
- cf_block  out  512  to sm3_CF
- cf_hash  in  256  from sm3_CF
- cf_end  in  1  from sm3_CF; result valid in the same cycle

Behaviour:
- Reset (async, low): state=IDLE; gnt, done, cf_start, wdog_err = 0; hash_out, cf_iv, cf_block, chain = 0; ptr = NREQ-1.
- State IDLE:
  - If req != 0, select the first set bit searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Register owner, set gnt[owner] = 1, go to LATCH.
- State LATCH:
  - cf_block <= blk_in[owner].
  - cf_iv <= first[owner] ? iv_in[owner] : chain.
  - last_q <= last[owner].
  - cf_start <= 1; go to RUN.
  - Latency: cf_start rises 2 cycles after req is sampled in IDLE.
- State RUN:
  - Hold cf_start, cf_iv and cf_block stable.
  - On cf_end: chain <= cf_hash, hash_out <= cf_hash, cf_start <= 0, done[owner] <= 1; go to GAP.
- State GAP:
  - done is high for this cycle only; cf_start = 0, giving at least one low cycle between starts.
  - If last_q: gnt <= 0, ptr <= owner; go to IDLE.
  - Otherwise go to WAIT.
- State WAIT:
  - The owner must present its next block, first and last by this cycle.
  - req[owner] = 1: go to LATCH.
  - req[owner] = 0: abort. Release gnt, ptr <= owner, go to IDLE; chain is discarded.
- Requests from non-owners are ignored while gnt != 0. They must hold req; there is no loss or queueing.
- Simultaneous requests resolve in round-robin order. Back-to-back messages from the same requester are allowed only after the other pending requesters are served.
- first = 1 on a non-initial block restarts the chain from iv_in (allowed).
- If cf_end arrives in any state other than RUN, it is ignored.
- Reset asserted mid-operation clears all state immediately; the partial message is lost and the requester must restart with first = 1.

Optional Feature:
- Macro: SM3_CF_WDOG_EN.
- With the macro:
  - A counter clears on entry to RUN and increments each cycle in RUN.
  - When it reaches WDOG_CYCLES with no cf_end: cf_start <= 0, wdog_err pulses for 1 cycle, done is NOT asserted, gnt is released, ptr <= owner, go to IDLE.
- Without the macro: RUN waits indefinitely and wdog_err is a constant 0.

Decomposition:
- Package sm3_pkg holds:
  - SM3_IV = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e
  - SM3_BLK_W = 512 and SM3_HASH_W = 256
  - state encoding: IDLE, LATCH, RUN, GAP, WAIT
- Sub-module rr_pick (NREQ): combinational round-robin select. Inputs req and ptr; outputs one-hot grant and index.

Test Plan:
- Single-block "abc": requester 0 sends one padded block (61626380 00..00 00000018) with first = 1, last = 1, iv = SM3_IV. Required: done[0] once; hash_out = 66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0; gnt drops in GAP.
- Two-block 512-bit "abcd"x16: requester 2 sends block 1 (first = 1) then the padding block (last = 1). Required: done pulses twice; second cf_iv equals the first hash_out; final hash = debe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732.
- Contention: req = 4'b1111 together, each requester sends one block. Required: grant order 0, 1, 2, 3, then wrap; no gnt overlap; cf_start low at least 1 cycle between consecutive starts.
- Abort: requester 1 drops req in WAIT after its first of three blocks. Required: gnt released, busy = 0 the next cycle, requester 3 (pending) granted next.
- Reset during RUN: reset low while cf_start = 1. Required: cf_start, gnt, done = 0 asynchronously; after release the next request runs normally and gives correct "abc" hash.
- Watchdog (SM3_CF_WDOG_EN, WDOG_CYCLES = 16): model never asserts cf_end. Required: wdog_err pulses on the 16th RUN cycle, done stays 0, scheduler returns to IDLE.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared constants and state encoding for the SM3 compression-core scheduler.
package sm3_pkg;

    localparam int SM3_BLK_W  = 512;
    localparam int SM3_HASH_W = 256;

    localparam logic [SM3_HASH_W-1:0] SM3_IV =
        256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        RUN,
        GAP,
        WAIT
    } state_t;

    // Index width for a requester number; at least one bit even for NREQ = 2.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sm3_cf_sched_rr_pick.sv
// Combinational round-robin selector: first set req bit after ptr, wrapping modulo NREQ.
module rr_pick
    import sm3_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    // cand[k] is the requester examined at search position k (ptr+1+k mod NREQ).
    logic [IW-1:0] cand [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        assign cand[gi] = IW'((32'(ptr) + 32'(gi) + 32'd1) % 32'(NREQ));
    end

    always_comb begin
        idx = '0;
        gnt = '0;
        // Walk from the farthest position back so the nearest hit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
            end
        end
        gnt[idx] = |req;
    end

endmodule

// File: rtl/sm3_cf_sched.sv
// Round-robin owner of one sm3_CF core; chains the digest across a message's blocks.
// Optional RUN-state watchdog abort is built when SM3_CF_WDOG_EN is defined.
module sm3_cf_sched
    import sm3_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            first,
    input  logic [NREQ-1:0]            last,
    input  logic [NREQ*SM3_HASH_W-1:0] iv_in,
    input  logic [NREQ*SM3_BLK_W-1:0]  blk_in,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [SM3_HASH_W-1:0]      hash_out,
    output logic                       busy,
    output logic                       wdog_err,
    output logic                       cf_start,
    output logic [SM3_HASH_W-1:0]      cf_iv,
    output logic [SM3_BLK_W-1:0]       cf_block,
    input  logic [SM3_HASH_W-1:0]      cf_hash,
    input  logic                       cf_end
);

    localparam int IW = idx_w(NREQ);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("sm3_cf_sched: NREQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    state_t                  state_q, state_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic [NREQ-1:0]         done_q, done_d;
    logic [SM3_HASH_W-1:0]   hash_q, hash_d;
    logic [SM3_HASH_W-1:0]   cf_iv_q, cf_iv_d;
    logic [SM3_BLK_W-1:0]    cf_block_q, cf_block_d;
    logic [SM3_HASH_W-1:0]   chain_q, chain_d;
    logic                    last_q, last_d;
    logic                    cf_start_q, cf_start_d;

    logic [NREQ-1:0]         pick_gnt;
    logic [IW-1:0]           pick_idx;
    logic [SM3_BLK_W-1:0]    own_blk;
    logic [SM3_HASH_W-1:0]   own_iv;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign own_blk = blk_in[int'(owner_q) * SM3_BLK_W +: SM3_BLK_W];
    assign own_iv  = iv_in[int'(owner_q) * SM3_HASH_W +: SM3_HASH_W];

`ifdef SM3_CF_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
    logic          wdog_err_q, wdog_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        hash_d     = hash_q;
        cf_iv_d    = cf_iv_q;
        cf_block_d = cf_block_q;
        chain_d    = chain_q;
        last_d     = last_q;
        cf_start_d = cf_start_q;
`ifdef SM3_CF_WDOG_EN
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick_idx;
                    gnt_d   = pick_gnt;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                cf_block_d = own_blk;
                cf_iv_d    = first[owner_q] ? own_iv : chain_q;
                last_d     = last[owner_q];
                cf_start_d = 1'b1;
                state_d    = RUN;
`ifdef SM3_CF_WDOG_EN
                wdog_cnt_d = '0;
`endif
            end
            RUN: begin
                if (cf_end) begin
                    chain_d    = cf_hash;
                    hash_d     = cf_hash;
                    cf_start_d = 1'b0;
                    done_d     = gnt_q;
                    state_d    = GAP;
                end
`ifdef SM3_CF_WDOG_EN
                else if (wdog_cnt_q == WW'(WDOG_CYCLES - 1)) begin
                    cf_start_d = 1'b0;
                    wdog_err_d = 1'b1;
                    gnt_d      = '0;
                    ptr_d      = owner_q;
                    state_d    = IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end
            GAP: begin
                if (last_q) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (req[owner_q]) begin
                    state_d = LATCH;
                end else begin
                    // Owner walked away mid-message: drop its partial chain.
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                    chain_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= IW'(NREQ - 1);
            gnt_q      <= '0;
            done_q     <= '0;
            hash_q     <= '0;
            cf_iv_q    <= '0;
            cf_block_q <= '0;
            chain_q    <= '0;
            last_q     <= 1'b0;
            cf_start_q <= 1'b0;
`ifdef SM3_CF_WDOG_EN
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            hash_q     <= hash_d;
            cf_iv_q    <= cf_iv_d;
            cf_block_q <= cf_block_d;
            chain_q    <= chain_d;
            last_q     <= last_d;
            cf_start_q <= cf_start_d;
`ifdef SM3_CF_WDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign hash_out = hash_q;
    assign busy     = (state_q != IDLE);
    assign cf_start = cf_start_q;
    assign cf_iv    = cf_iv_q;
    assign cf_block = cf_block_q;
`ifdef SM3_CF_WDOG_EN
    assign wdog_err = wdog_err_q;
`else
    assign wdog_err = 1'b0;
`endif

endmodule
